// File: rtl/data_mem_multi_pkg.sv
// Shared types, sizes and the byte-merge helper for the multi-port data memory.
package data_mem_multi_pkg;

    localparam int DATA_MEM_WIDTH = 10;
    localparam int DATA_MEM_DEPTH = 1 << DATA_MEM_WIDTH;

    // Widest word merge_be handles; callers extend to this width and truncate back.
    localparam int MERGE_MAX_W = 128;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } data_mem_state_t;

    function automatic logic [MERGE_MAX_W-1:0] merge_be(
        input logic [MERGE_MAX_W-1:0]   old_w,
        input logic [MERGE_MAX_W-1:0]   new_w,
        input logic [MERGE_MAX_W/8-1:0] be
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MERGE_MAX_W / 8; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mem_rd_port.sv
// One read port: asynchronous word passthrough or a registered copy with write-first bypass.
module data_mem_rd_port
    import data_mem_multi_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = DATA_MEM_WIDTH,
    parameter int RD_LAT = 0
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 busy_i,
    input  logic [ADDR_W-1:0]    rd_addr_i,
    input  logic [WIDTH-1:0]     mem_word_i,
    input  logic                 wr_fire_i,
    input  logic [ADDR_W-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0]     wr_data_i,
    input  logic [WIDTH/8-1:0]   wr_be_i,
    output logic [WIDTH-1:0]     rd_data_o
);

    logic [WIDTH-1:0] rd_q;
    logic [WIDTH-1:0] rd_d;
    logic [WIDTH-1:0] bypass_word;

    assign bypass_word = WIDTH'(merge_be(MERGE_MAX_W'(mem_word_i),
                                         MERGE_MAX_W'(wr_data_i),
                                         (MERGE_MAX_W/8)'(wr_be_i)));

    always_comb begin
        rd_d = mem_word_i;
        if (busy_i) begin
            rd_d = '0;
        end else if (wr_fire_i && (wr_addr_i == rd_addr_i)) begin
            rd_d = bypass_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    // With zero latency the register is left dangling and optimised away.
    assign rd_data_o = (RD_LAT == 0) ? mem_word_i : rd_q;

endmodule

// File: rtl/data_mem_multi.sv
// Byte-enabled write port, N_RD read ports and a post-reset zero-fill FSM.
// Define DATA_MEM_INIT_EN to skip the zero-fill and keep contents across reset.
module data_mem_multi
    import data_mem_multi_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = DATA_MEM_WIDTH,
    parameter int N_RD   = 2,
    parameter int RD_LAT = 0
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic [WIDTH/8-1:0]           wr_be,
    input  logic [N_RD-1:0][ADDR_W-1:0]  rd_addr,
    output logic [N_RD-1:0][WIDTH-1:0]   rd_data,
    output logic                         busy
);

    localparam int DEPTH = 1 << ADDR_W;

    (* ram_style = "distributed" *) logic [WIDTH-1:0] mem_q [DEPTH];

    data_mem_state_t   state_q;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_fire;
    logic [WIDTH-1:0]  wr_merged;

`ifdef DATA_MEM_INIT_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= READY;
        end
    end

    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`else
    logic [ADDR_W-1:0] clr_cnt_q;

    // The last clear write and the move to READY share one edge, so busy spans DEPTH cycles.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else if (state_q == CLEAR) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (&clr_cnt_q) begin
                state_q <= READY;
            end
        end
    end

    assign clr_we   = rstn && (state_q == CLEAR);
    assign clr_addr = clr_cnt_q;
`endif

    assign wr_ready  = (state_q == READY);
    assign busy      = (state_q == CLEAR);
    assign wr_fire   = rstn && wr_valid && wr_ready;
    assign wr_merged = WIDTH'(merge_be(MERGE_MAX_W'(mem_q[wr_addr]),
                                       MERGE_MAX_W'(wr_data),
                                       (MERGE_MAX_W/8)'(wr_be)));

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_fire) begin
            mem_q[wr_addr] <= wr_merged;
        end
    end

    for (genvar p = 0; p < N_RD; p++) begin : g_rd
        data_mem_rd_port #(
            .WIDTH  (WIDTH),
            .ADDR_W (ADDR_W),
            .RD_LAT (RD_LAT)
        ) u_rd_port (
            .clk_i      (clk),
            .rstn_i     (rstn),
            .busy_i     (busy),
            .rd_addr_i  (rd_addr[p]),
            .mem_word_i (mem_q[rd_addr[p]]),
            .wr_fire_i  (wr_fire),
            .wr_addr_i  (wr_addr),
            .wr_data_i  (wr_data),
            .wr_be_i    (wr_be),
            .rd_data_o  (rd_data[p])
        );
    end

endmodule

// File: tb/tb_data_mem_multi.sv
// Directed bench for data_mem_multi: one RD_LAT=0 and one RD_LAT=1 instance on shared inputs.
module tb_data_mem_multi;

    logic             clk = 1'b0;
    logic             rstn;
    logic             wr_valid;
    logic [9:0]       wr_addr;
    logic [31:0]      wr_data;
    logic [3:0]       wr_be;
    logic [1:0][9:0]  rd_addr;

    logic             wr_ready0, wr_ready1;
    logic             busy0, busy1;
    logic [1:0][31:0] rd_data0, rd_data1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    data_mem_multi #(.WIDTH(32), .ADDR_W(10), .N_RD(2), .RD_LAT(0)) dut0 (
        .clk(clk), .rstn(rstn), .wr_valid(wr_valid), .wr_ready(wr_ready0),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_addr(rd_addr), .rd_data(rd_data0), .busy(busy0)
    );

    data_mem_multi #(.WIDTH(32), .ADDR_W(10), .N_RD(2), .RD_LAT(1)) dut1 (
        .clk(clk), .rstn(rstn), .wr_valid(wr_valid), .wr_ready(wr_ready1),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_addr(rd_addr), .rd_data(rd_data1), .busy(busy1)
    );

    typedef struct {
        logic        wv;
        logic [9:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [9:0]  ra0;
        logic [9:0]  ra1;
        logic [31:0] a0;  // async ports, sampled before the edge
        logic [31:0] a1;
        logic [31:0] r0;  // registered ports, sampled after the edge
        logic [31:0] r1;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs clear cycles until busy drops; returns cycles counted (bounded).
    task automatic count_clear(input int pulse_at, output int cnt);
        cnt = 0;
        while (cnt < 2000) begin
            tick();
            cnt++;
            if (cnt == pulse_at) begin
                wr_valid = 1'b1;
                wr_addr  = 10'h010;
                wr_data  = 32'hFFFF_FFFF;
                wr_be    = 4'hF;
                #1;
                check("wr_ready_during_busy", {31'd0, wr_ready0}, 32'd0);
            end else begin
                wr_valid = 1'b0;
            end
            if (!busy0) break;
        end
    endtask

    initial begin
        int cnt;

        vecs[0] = '{1'b0, 10'h000, 32'h0000_0000, 4'h0, 10'h000, 10'h3FF,
                    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[1] = '{1'b0, 10'h000, 32'h0000_0000, 4'h0, 10'h155, 10'h010,
                    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[2] = '{1'b1, 10'h010, 32'hDEAD_BEEF, 4'hF, 10'h010, 10'h010,
                    32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 10'h010, 32'h1122_3344, 4'h5, 10'h010, 10'h3FF,
                    32'hDEAD_BEEF, 32'h0000_0000, 32'hDE22_BE44, 32'h0000_0000};
        vecs[4] = '{1'b0, 10'h000, 32'h0000_0000, 4'h0, 10'h010, 10'h010,
                    32'hDE22_BE44, 32'hDE22_BE44, 32'hDE22_BE44, 32'hDE22_BE44};
        vecs[5] = '{1'b1, 10'h020, 32'hAAAA_AAAA, 4'hF, 10'h020, 10'h010,
                    32'h0000_0000, 32'hDE22_BE44, 32'hAAAA_AAAA, 32'hDE22_BE44};
        vecs[6] = '{1'b1, 10'h020, 32'h5555_5555, 4'h3, 10'h020, 10'h020,
                    32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_5555, 32'hAAAA_5555};
        vecs[7] = '{1'b1, 10'h020, 32'hFFFF_FFFF, 4'h0, 10'h020, 10'h3FF,
                    32'hAAAA_5555, 32'h0000_0000, 32'hAAAA_5555, 32'h0000_0000};
        vecs[8] = '{1'b1, 10'h3FF, 32'hCAFE_F00D, 4'h8, 10'h3FF, 10'h020,
                    32'h0000_0000, 32'hAAAA_5555, 32'hCA00_0000, 32'hAAAA_5555};
        vecs[9] = '{1'b0, 10'h000, 32'h0000_0000, 4'h0, 10'h3FF, 10'h000,
                    32'hCA00_0000, 32'h0000_0000, 32'hCA00_0000, 32'h0000_0000};

        rstn = 1'b0;
        wr_valid = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_be = '0;
        rd_addr = '0;

        repeat (3) tick();
        check("reset_busy", {31'd0, busy0}, 32'd1);
        check("reset_wr_ready", {31'd0, wr_ready0}, 32'd0);
        check("reset_rd1_p0", rd_data1[0], 32'd0);
        check("reset_rd1_p1", rd_data1[1], 32'd0);

        rstn = 1'b1;
        count_clear(0, cnt);
        check("clear_cycles", cnt, 32'd1024);
        check("ready_wr_ready0", {31'd0, wr_ready0}, 32'd1);
        check("ready_wr_ready1", {31'd0, wr_ready1}, 32'd1);
        check("ready_busy1", {31'd0, busy1}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            wr_valid   = vecs[i].wv;
            wr_addr    = vecs[i].wa;
            wr_data    = vecs[i].wd;
            wr_be      = vecs[i].be;
            rd_addr[0] = vecs[i].ra0;
            rd_addr[1] = vecs[i].ra1;
            #1;
            check($sformatf("vec%0d_async_p0", i), rd_data0[0], vecs[i].a0);
            check($sformatf("vec%0d_async_p1", i), rd_data0[1], vecs[i].a1);
            tick();
            wr_valid = 1'b0;
            check($sformatf("vec%0d_reg_p0", i), rd_data1[0], vecs[i].r0);
            check($sformatf("vec%0d_reg_p1", i), rd_data1[1], vecs[i].r1);
        end

        // Reset during clear: restart at cycle 500, then a write pulse mid-clear.
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        repeat (500) tick();
        check("midclear_busy", {31'd0, busy0}, 32'd1);
        check("midclear_rd1_zero", rd_data1[0], 32'd0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        count_clear(100, cnt);
        check("reclear_cycles", cnt, 32'd1024);

        rd_addr[0] = 10'h010;
        rd_addr[1] = 10'h3FF;
        #1;
        check("post_clear_async_010", rd_data0[0], 32'd0);
        check("post_clear_async_3ff", rd_data0[1], 32'd0);
        tick();
        check("post_clear_reg_010", rd_data1[0], 32'd0);
        check("post_clear_reg_3ff", rd_data1[1], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
